dynamixel_status_receiver: RTL

Parses Dynamixel Protocol 2.0 status packets arriving byte-by-byte from the UART receiver on the servo bus return path; it is the receive-side counterpart to the sync-write position transmitter. It performs header hunting, byte de-stuffing, CRC-16 checking and inter-byte timeout recovery. For each valid packet it presents the servo ID, error byte and up to four parameter bytes, e.g. the present position from a read, to the controller logic.

---
 rtl/dynamixel_status_receiver_if.sv | 25 ++
 rtl/dynamixel_status_receiver.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dynamixel_status_receiver_if.sv
// Byte stream in from the UART receiver and decoded status packet out to the controller.
interface dynamixel_status_receiver_if;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        status_valid;
    logic [7:0]  status_id;
    logic [7:0]  status_error;
    logic [31:0] status_data;
    logic [7:0]  status_param_count;
    logic        crc_error;
    logic        frame_error;
    logic        busy;

    modport master (
        output rx_valid, rx_byte,
        input  status_valid, status_id, status_error, status_data,
        input  status_param_count, crc_error, frame_error, busy
    );

    modport slave (
        input  rx_valid, rx_byte,
        output status_valid, status_id, status_error, status_data,
        output status_param_count, crc_error, frame_error, busy
    );
endinterface

// File: rtl/dynamixel_status_receiver.sv
// Dynamixel 2.0 status packet parser: header hunt, de-stuffing, CRC-16 check and
// inter-byte timeout recovery.
module dynamixel_status_receiver #(
    parameter int unsigned clocks_per_timeout = 100000,
    parameter int unsigned max_length         = 64
) (
    input  logic                          clock,
    input  logic                          reset,
    dynamixel_status_receiver_if.slave    bus
);

    typedef enum logic [3:0] {
        S_HUNT, S_ID, S_LEN_L, S_LEN_H, S_INSTR, S_ERR, S_PARAM, S_CRC_L, S_CRC_H
    } state_t;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
        end
        return c;
    endfunction

    localparam int unsigned      TO_W     = $clog2(clocks_per_timeout + 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(clocks_per_timeout - 1);
    localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
    localparam logic [15:0]      MAX_LEN  = 16'(max_length);
    // The header is fixed, so its CRC contribution is a constant preloaded on the match.
    localparam logic [15:0]      HDR_CRC  = crc16_byte(crc16_byte(crc16_byte(crc16_byte(
                                                16'h0000, 8'hFF), 8'hFF), 8'hFD), 8'h00);

    state_t            state_q, state_d;
    logic [23:0]       shift_q, shift_d;
    logic [23:0]       stuff_q, stuff_d;
    logic [15:0]       crc_q, crc_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       rem_q, rem_d;
    logic [7:0]        crc_lo_q, crc_lo_d;
    logic [7:0]        id_q, id_d;
    logic [7:0]        err_q, err_d;
    logic [31:0]       data_q, data_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              status_valid_q, status_valid_d;
    logic              crc_error_q, crc_error_d;
    logic              frame_error_q, frame_error_d;
    logic              busy_q, busy_d;
    logic [7:0]        status_id_q, status_id_d;
    logic [7:0]        status_error_q, status_error_d;
    logic [31:0]       status_data_q, status_data_d;
    logic [7:0]        status_param_count_q, status_param_count_d;
    logic [15:0]       crc_next_s;
    logic [15:0]       len_full_s;
    logic              stuffed_s;

    assign crc_next_s = crc16_byte(crc_q, bus.rx_byte);
    assign len_full_s = {bus.rx_byte, len_q[7:0]};
    assign stuffed_s  = (stuff_q == 24'hFFFFFD) && (bus.rx_byte == 8'hFD);

    // Next-state and next-output computation for the packet parser.
    always_comb begin
        state_d              = state_q;
        shift_d              = shift_q;
        stuff_d              = stuff_q;
        crc_d                = crc_q;
        len_d                = len_q;
        rem_d                = rem_q;
        crc_lo_d             = crc_lo_q;
        id_d                 = id_q;
        err_d                = err_q;
        data_d               = data_q;
        cnt_d                = cnt_q;
        to_d                 = to_q;
        status_valid_d       = 1'b0;
        crc_error_d          = 1'b0;
        frame_error_d        = 1'b0;
        status_id_d          = status_id_q;
        status_error_d       = status_error_q;
        status_data_d        = status_data_q;
        status_param_count_d = status_param_count_q;

        if (bus.rx_valid) begin
            to_d = '0;
            case (state_q)
                S_HUNT: begin
                    if ((shift_q == 24'hFFFFFD) && (bus.rx_byte == 8'h00)) begin
                        state_d = S_ID;
                        shift_d = 24'h000000;
                        crc_d   = HDR_CRC;
                    end else begin
                        shift_d = {shift_q[15:0], bus.rx_byte};
                    end
                end
                S_ID: begin
                    id_d    = bus.rx_byte;
                    crc_d   = crc_next_s;
                    state_d = S_LEN_L;
                end
                S_LEN_L: begin
                    len_d   = {8'h00, bus.rx_byte};
                    crc_d   = crc_next_s;
                    state_d = S_LEN_H;
                end
                S_LEN_H: begin
                    len_d = len_full_s;
                    crc_d = crc_next_s;
                    if ((len_full_s < 16'd4) || (len_full_s > MAX_LEN)) begin
                        frame_error_d = 1'b1;
                        state_d       = S_HUNT;
                    end else begin
                        state_d = S_INSTR;
                    end
                end
                S_INSTR: begin
                    crc_d = crc_next_s;
                    if (bus.rx_byte == 8'h55) begin
                        state_d = S_ERR;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = S_HUNT;
                    end
                end
                S_ERR: begin
                    err_d   = bus.rx_byte;
                    crc_d   = crc_next_s;
                    data_d  = 32'h00000000;
                    cnt_d   = 8'h00;
                    stuff_d = 24'h000000;
                    rem_d   = len_q - 16'd4;
                    state_d = (len_q == 16'd4) ? S_CRC_L : S_PARAM;
                end
                S_PARAM: begin
                    crc_d   = crc_next_s;
                    stuff_d = {stuff_q[15:0], bus.rx_byte};
                    rem_d   = rem_q - 16'd1;
                    // A stuffed FD still counts toward length and CRC, but is not data.
                    if (!stuffed_s) begin
                        if (cnt_q < 8'd4) begin
                            data_d[{cnt_q[1:0], 3'b000} +: 8] = bus.rx_byte;
                        end else begin
                            data_d = data_q;
                        end
                        cnt_d = cnt_q + 8'd1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                    if (rem_q == 16'd1) begin
                        state_d = S_CRC_L;
                    end else begin
                        state_d = S_PARAM;
                    end
                end
                S_CRC_L: begin
                    crc_lo_d = bus.rx_byte;
                    state_d  = S_CRC_H;
                end
                S_CRC_H: begin
                    state_d = S_HUNT;
                    if ({bus.rx_byte, crc_lo_q} == crc_q) begin
                        status_valid_d       = 1'b1;
                        status_id_d          = id_q;
                        status_error_d       = err_q;
                        status_data_d        = data_q;
                        status_param_count_d = cnt_q;
                    end else begin
                        crc_error_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_HUNT;
                end
            endcase
        end else if (state_q != S_HUNT) begin
            if (to_q == TO_LAST) begin
                frame_error_d = 1'b1;
                state_d       = S_HUNT;
                to_d          = '0;
            end else begin
                to_d = to_q + TO_ONE;
            end
        end else begin
            to_d = '0;
        end

        busy_d = (state_d != S_HUNT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q              <= S_HUNT;
            shift_q              <= 24'h000000;
            stuff_q              <= 24'h000000;
            crc_q                <= 16'h0000;
            len_q                <= 16'h0000;
            rem_q                <= 16'h0000;
            crc_lo_q             <= 8'h00;
            id_q                 <= 8'h00;
            err_q                <= 8'h00;
            data_q               <= 32'h00000000;
            cnt_q                <= 8'h00;
            to_q                 <= '0;
            status_valid_q       <= 1'b0;
            crc_error_q          <= 1'b0;
            frame_error_q        <= 1'b0;
            busy_q               <= 1'b0;
            status_id_q          <= 8'h00;
            status_error_q       <= 8'h00;
            status_data_q        <= 32'h00000000;
            status_param_count_q <= 8'h00;
        end else begin
            state_q              <= state_d;
            shift_q              <= shift_d;
            stuff_q              <= stuff_d;
            crc_q                <= crc_d;
            len_q                <= len_d;
            rem_q                <= rem_d;
            crc_lo_q             <= crc_lo_d;
            id_q                 <= id_d;
            err_q                <= err_d;
            data_q               <= data_d;
            cnt_q                <= cnt_d;
            to_q                 <= to_d;
            status_valid_q       <= status_valid_d;
            crc_error_q          <= crc_error_d;
            frame_error_q        <= frame_error_d;
            busy_q               <= busy_d;
            status_id_q          <= status_id_d;
            status_error_q       <= status_error_d;
            status_data_q        <= status_data_d;
            status_param_count_q <= status_param_count_d;
        end
    end

    assign bus.status_valid       = status_valid_q;
    assign bus.crc_error          = crc_error_q;
    assign bus.frame_error        = frame_error_q;
    assign bus.busy               = busy_q;
    assign bus.status_id          = status_id_q;
    assign bus.status_error       = status_error_q;
    assign bus.status_data        = status_data_q;
    assign bus.status_param_count = status_param_count_q;

endmodule
